// File: rtl/i_type_seq.sv
// i_type_seq: four-state sequencer (IDLE/READ/EXEC/WB) for I-type ALU ops over a 32x64 register file.
// Define I_SEQ_TRAP_EN to trap illegal ctrl codes via err instead of executing them as ADDI.
module i_type_seq #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      ctrl,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rd,
    input  logic [11:0]     imm,
    input  logic            ld_valid,
    input  logic [4:0]      ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            err,
    output logic            busy
);
    localparam logic [5:0] ADDI  = 6'b100000;
    localparam logic [5:0] SUBI  = 6'b101000;
    localparam logic [5:0] ANDI  = 6'b100111;
    localparam logic [5:0] ORI   = 6'b100110;
    localparam logic [5:0] NORI  = 6'b101111;
    localparam logic [5:0] NANDI = 6'b101110;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t          r_state;
    logic [5:0]      r_ctrl;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rd;
    logic [11:0]     r_imm;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_done;
    logic            r_err;
    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] w_alu;
    logic            w_legal;
    logic            w_trap;

    always_comb begin
        w_alu   = r_ctrl == SUBI  ? r_a - r_b :
                  r_ctrl == ANDI  ? r_a & r_b :
                  r_ctrl == ORI   ? r_a | r_b :
                  r_ctrl == NORI  ? ~(r_a | r_b) :
                  r_ctrl == NANDI ? ~(r_a & r_b) : r_a + r_b;
        w_legal = r_ctrl inside {ADDI, SUBI, ANDI, ORI, NORI, NANDI};
    end

`ifdef I_SEQ_TRAP_EN
    assign w_trap = !w_legal;
`else
    assign w_trap = 1'b0;
`endif

    assign in_ready = r_state == IDLE;
    assign busy     = r_state != IDLE;
    assign dbg_data = r_regs[dbg_addr];
    assign result   = r_result;
    assign done     = r_done;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ctrl   <= '0;
            r_rs1    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // x0 is never written, so it always reads back as zero
                    if (ld_valid && ld_addr != '0) r_regs[ld_addr] <= ld_data;
                    if (in_valid) begin
                        r_ctrl  <= ctrl;
                        r_rs1   <= rs1;
                        r_rd    <= rd;
                        r_imm   <= imm;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_a     <= r_regs[r_rs1];
                    r_b     <= {{(XLEN-12){r_imm[11]}}, r_imm};
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (!w_trap) r_result <= w_alu;
                    r_done  <= !w_trap;
                    r_err   <= w_trap;
                    r_state <= WB;
                end
                default: begin
                    if (!w_trap && r_rd != '0) r_regs[r_rd] <= r_result;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i_type_seq.sv
// tb_i_type_seq: directed checks of i_type_seq ALU ops, latency, hazards, busy, illegal ctrl and reset.
module tb_i_type_seq;
    localparam logic [5:0] ADDI  = 6'b100000;
    localparam logic [5:0] SUBI  = 6'b101000;
    localparam logic [5:0] ANDI  = 6'b100111;
    localparam logic [5:0] ORI   = 6'b100110;
    localparam logic [5:0] NORI  = 6'b101111;
    localparam logic [5:0] NANDI = 6'b101110;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [5:0]  ctrl = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rd = '0;
    logic [11:0] imm = '0;
    logic        ld_valid = 0;
    logic [4:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [63:0] dbg_data;
    logic [63:0] result;
    logic        done;
    logic        err;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    i_type_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .rs1(rs1), .rd(rd), .imm(imm),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .result(result), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [4:0] a, input logic [63:0] d);
        ld_valid = 1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [63:0] v);
        dbg_addr = a;
        #1 v = dbg_data;
    endtask

    // Returns cycles from acceptance edge to done/err (10 on timeout) and ends in the cycle after WB.
    task automatic issue(input logic [5:0] c, input logic [4:0] s, input logic [4:0] d,
                         input logic [11:0] i, output int lat, output bit saw_done, output bit saw_err);
        ctrl = c; rs1 = s; rd = d; imm = i; in_valid = 1;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; ctrl = '0; rs1 = '1; rd = '1; imm = '1;
        lat = 1;
        while (!done && !err && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        saw_done = done; saw_err = err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [63:0] v;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        peek(5'd7, v);
        checks++; if (v !== 64'h0) begin errors++; $display("FAIL reset_x7 got %h want 0", v); end
    endtask

    task automatic test_addi;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        load(5'd2, 64'd5);
        issue(ADDI, 5'd2, 5'd7, 12'hFFA, lat, dn, er);
        checks++; if (lat !== 3) begin errors++; $display("FAIL addi_latency got %0d want 3", lat); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_pulse got %b want 0", done); end
        peek(5'd7, v);
        checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_x7 got %h want ffffffffffffffff", v); end
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_result got %h want ffffffffffffffff", result); end
    endtask

    task automatic test_subi_andi;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        load(5'd1, 64'd10);
        issue(SUBI, 5'd1, 5'd7, 12'd2, lat, dn, er);
        peek(5'd7, v);
        checks++; if (v !== 64'd8) begin errors++; $display("FAIL subi_x7 got %h want 8", v); end
        @(negedge clk);
        load(5'd2, 64'hFF);
        issue(ANDI, 5'd2, 5'd3, 12'hE2A, lat, dn, er);
        peek(5'd3, v);
        checks++; if (v !== 64'h2A) begin errors++; $display("FAIL andi_x3 got %h want 2a", v); end
        checks++; if (lat !== 3 || !dn) begin errors++; $display("FAIL andi_latency got %0d/%b want 3/1", lat, dn); end
    endtask

    task automatic test_logic_ops;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        load(5'd2, 64'h0);
        issue(ORI, 5'd2, 5'd11, 12'hFEA, lat, dn, er);
        peek(5'd11, v);
        checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFEA) begin errors++; $display("FAIL ori_x11 got %h want ffffffffffffffea", v); end
        issue(NORI, 5'd2, 5'd12, 12'h01D, lat, dn, er);
        peek(5'd12, v);
        checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFE2) begin errors++; $display("FAIL nori_x12 got %h want ffffffffffffffe2", v); end
        issue(NANDI, 5'd2, 5'd13, 12'h000, lat, dn, er);
        peek(5'd13, v);
        checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL nandi_x13 got %h want ffffffffffffffff", v); end
    endtask

    task automatic test_illegal;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        load(5'd2, 64'd3);
        load(5'd5, 64'd9);
        issue(6'b000000, 5'd2, 5'd5, 12'd4, lat, dn, er);
        peek(5'd5, v);
`ifdef I_SEQ_TRAP_EN
        checks++; if (er !== 1'b1 || dn !== 1'b0 || lat !== 3) begin errors++; $display("FAIL illegal_trap got err=%b done=%b lat=%0d want 1 0 3", er, dn, lat); end
        checks++; if (v !== 64'd9) begin errors++; $display("FAIL illegal_x5 got %h want 9", v); end
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL illegal_result got %h want ffffffffffffffff", result); end
`else
        checks++; if (er !== 1'b0 || dn !== 1'b1 || lat !== 3) begin errors++; $display("FAIL illegal_addi got err=%b done=%b lat=%0d want 0 1 3", er, dn, lat); end
        checks++; if (v !== 64'd7) begin errors++; $display("FAIL illegal_x5 got %h want 7", v); end
        checks++; if (result !== 64'd7) begin errors++; $display("FAIL illegal_result got %h want 7", result); end
`endif
    endtask

    task automatic test_back_to_back;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        issue(ADDI, 5'd0, 5'd0, 12'd5, lat, dn, er);
        peek(5'd0, v);
        checks++; if (v !== 64'h0) begin errors++; $display("FAIL x0_write got %h want 0", v); end
        checks++; if (result !== 64'd5) begin errors++; $display("FAIL x0_result got %h want 5", result); end
        @(negedge clk);
        issue(ADDI, 5'd0, 5'd4, 12'd12, lat, dn, er);
        issue(ADDI, 5'd4, 5'd10, 12'd1, lat, dn, er);
        peek(5'd10, v);
        checks++; if (v !== 64'd13) begin errors++; $display("FAIL hazard_x10 got %h want d", v); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL hazard_latency got %0d want 3", lat); end
    endtask

    task automatic test_busy;
        logic [63:0] v;
        @(negedge clk);
        ctrl = ADDI; rs1 = 5'd8; rd = 5'd8; imm = 12'd1; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_read got ready=%b busy=%b want 0 1", in_ready, busy); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_exec_ready got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL busy_wb got done=%b ready=%b want 1 0", done, in_ready); end
        in_valid = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_extra_accept got %b want 0", busy); end
        peek(5'd8, v);
        checks++; if (v !== 64'd1) begin errors++; $display("FAIL busy_x8 got %h want 1", v); end
    endtask

    task automatic test_reset_mid;
        int lat; bit dn, er; logic [63:0] v;
        @(negedge clk);
        load(5'd9, 64'd7);
        ctrl = ADDI; rs1 = 5'd0; rd = 5'd6; imm = 12'd3; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got done=%b ready=%b busy=%b want 0 1 0", done, in_ready, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_late_done got %b want 0", done); end
        peek(5'd6, v);
        checks++; if (v !== 64'h0) begin errors++; $display("FAIL rstmid_x6 got %h want 0", v); end
        peek(5'd9, v);
        checks++; if (v !== 64'h0) begin errors++; $display("FAIL rstmid_x9 got %h want 0", v); end
        @(negedge clk);
        issue(ADDI, 5'd0, 5'd6, 12'd4, lat, dn, er);
        peek(5'd6, v);
        checks++; if (v !== 64'd4 || lat !== 3) begin errors++; $display("FAIL rstmid_after got x6=%h lat=%0d want 4 3", v, lat); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_addi();
        test_subi_andi();
        test_logic_ops();
        test_illegal();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i_type_seq.md
# i_type_seq

Multi-cycle sequencer for immediate-type instructions. It accepts one decoded I-type instruction per handshake and steps it through register read, ALU execute and register writeback. It owns the 32 x 64-bit register file and the six-operation immediate ALU. It sits between the instruction decoder (upstream, valid/ready) and the architectural state, and exposes a load port and a debug read port for initialisation and checking.

## Interface
- `XLEN`, 64, datapath and register width
- `NREG`, 32, register count; register 0 is hardwired to zero
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: instruction fields are valid
- `in_ready` output 1: sequencer can accept an instruction
- `ctrl` input 6: ALU operation code
- `rs1` input 5: source register index
- `rd` input 5: destination register index
- `imm` input 12: immediate, two's complement
- `ld_valid` input 1: register-file load request
- `ld_addr` input 5: load target index
- `ld_data` input XLEN: load value
- `dbg_addr` input 5: debug read index
- `dbg_data` output XLEN: combinational read of `dbg_addr`
- `result` output XLEN: last computed ALU result
- `done` output 1: one-cycle pulse in the writeback cycle
- `err` output 1: one-cycle pulse on an illegal `ctrl` (only when `I_SEQ_TRAP_EN` is defined)
- `busy` output 1: asserted whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` && `in_ready`, latch `ctrl`, `rs1`, `rd` and `imm`, then go to READ.
- **READ**
  - Latch operand A = reg[rs1]; reg[0] always reads 0.
  - Latch B = sign-extend(imm) to XLEN.
- **EXEC**
  - Compute into the `result` register:
    - 6'b100000 ADDI: A+B
    - 6'b101000 SUBI: A-B
    - 6'b100111 ANDI: A&B
    - 6'b100110 ORI: A|B
    - 6'b101111 NORI: ~(A|B)
    - 6'b101110 NANDI: ~(A&B)
  - Arithmetic is modulo 2^XLEN; there is no overflow flag.
- **WB**
  - Write `result` to reg[rd] unless rd==0.
  - Pulse `done`, then return to IDLE.
- **Load port**
  - Honoured only in IDLE: reg[ld_addr] <= ld_data; writes with ld_addr==0 are discarded.
  - A load in the same cycle as an instruction acceptance is performed, and that instruction's READ sees the loaded value.
  - `ld_valid` outside IDLE is ignored.
- **Illegal `ctrl`**: any code not listed above; handling is defined under Configuration.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `busy`=0, `done`=0, `err`=0, `result`=0, all registers 0.
- **Latency:** handshake on edge N.
  - READ occupies cycle N+1 and EXEC occupies cycle N+2.
  - `done`=1 during cycle N+3, and the register write lands on the edge ending N+3.
  - `in_ready` returns to 1 in cycle N+4.
- **Throughput:** one instruction per 4 cycles; `in_ready`=0 from READ through WB.
- Instruction inputs are sampled only at acceptance; changes afterwards have no effect.
- `dbg_data` reflects register contents combinationally, so a WB write is visible the cycle after WB.
- **`rst` mid-operation:** the FSM returns to IDLE on the next edge, the pending write is dropped, and the register file is cleared.
- Back-to-back instructions whose rs1 equals the previous rd observe the written value, because the write completes before the next READ.

## Configuration
- `I_SEQ_TRAP_EN` defined:
  - An illegal `ctrl` pulses `err` in the WB cycle instead of `done`.
  - No register write occurs, and `result` holds its previous value.
- `I_SEQ_TRAP_EN` undefined:
  - An illegal `ctrl` executes as ADDI, with a normal write and `done` pulse.
  - `err` is tied to 0.

## Test plan
- ADDI, sign-extended negative immediate:
  - Stimulus: load x2=5; issue ADDI rs1=2, imm=12'hFFA (-6), rd=7.
  - Response: `done` 3 cycles after acceptance; x7=64'hFFFF_FFFF_FFFF_FFFF; `result` matches.
- SUBI and ANDI:
  - SUBI: load x1=10; issue SUBI rs1=1, imm=2, rd=7 -> x7=8.
  - ANDI: load x2=64'hFF; issue ANDI rs1=2, imm=12'hE2A, rd=3 -> x3=64'h2A.
- ORI, NORI and NANDI with x2=0:
  - ORI imm=12'hFEA -> 64'hFFFF_FFFF_FFFF_FFEA.
  - NORI imm=12'h01D -> 64'hFFFF_FFFF_FFFF_FFE2.
  - NANDI imm=0 -> all ones.
- Register 0, back-to-back hazard and busy behaviour:
  - ADDI rs1=0, imm=5, rd=0 -> x0 stays 0.
  - Then ADDI rd=4 followed immediately by ADDI rs1=4 -> the second instruction uses the updated x4.
  - `in_valid` held high while busy -> no extra acceptance.
- Illegal `ctrl` 6'b000000 with rd=5 and x5 preloaded to 9:
  - With `I_SEQ_TRAP_EN`: `err` pulse, no `done`, x5 stays 9.
  - Without it: x5 = x[rs1]+imm.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle during EXEC of an ADDI to rd=6.
  - Response: x6=0, no `done`, `in_ready`=1 the cycle after reset, and a new instruction is accepted normally.
